sgd_mem_wr_engine: RTL



---
 rtl/sgd_mem_wr_engine.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sgd_mem_wr_engine.sv
// sgd_mem_wr_engine
//   Write-side initiator for the SGD memory path. A job (base byte address, byte length) is split
//   into memory write commands of at most MAX_CMD_BYTES each. After each command the producer
//   stream is forwarded beat-for-beat to the memory stream, and the job completes once one status
//   has been collected per issued command.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   start, base_addr, total_len     job request (sampled only while idle)
//   busy, done, error               job state; done is a one-cycle pulse, error is sticky per job
//   m_cmd_*                         write command out (address, byte length)
//   s_data_*                        producer stream in
//   m_data_*                        memory stream out (keep all ones, last per command)
//   s_status_*                      per-command status in (0 = OK)
module sgd_mem_wr_engine #(
   parameter int unsigned MAX_CMD_BYTES = 4096,
   parameter int unsigned DATA_WIDTH    = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [63:0]             base_addr,
   input  logic [31:0]             total_len,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic                    m_cmd_valid,
   input  logic                    m_cmd_ready,
   output logic [63:0]             m_cmd_address,
   output logic [31:0]             m_cmd_length,
   input  logic                    s_data_valid,
   output logic                    s_data_ready,
   input  logic [DATA_WIDTH-1:0]   s_data_data,
   output logic                    m_data_valid,
   input  logic                    m_data_ready,
   output logic [DATA_WIDTH-1:0]   m_data_data,
   output logic [DATA_WIDTH/8-1:0] m_data_keep,
   output logic                    m_data_last,
   input  logic                    s_status_valid,
   output logic                    s_status_ready,
   input  logic [7:0]              s_status_data
);

   localparam int unsigned BeatBytes = DATA_WIDTH / 8;
   localparam int unsigned BeatShift = $clog2(BeatBytes);
   localparam logic [31:0] MaxCmdLen = 32'(MAX_CMD_BYTES);

   typedef enum logic [2:0] {StIdle, StCmd, StData, StWaitSts, StFin} state_e;

   state_e      state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] remaining_q, remaining_d;
   logic [31:0] chunk_beats_q, chunk_beats_d;
   logic [31:0] beat_cnt_q, beat_cnt_d;
   logic [31:0] cmd_cnt_q, cmd_cnt_d;
   logic [31:0] sts_cnt_q, sts_cnt_d;
   logic        error_q, error_d;

   logic [31:0] cmd_len;
   logic [31:0] cmd_beats;

   // cmd_len never exceeds MAX_CMD_BYTES, so the rounding add cannot overflow 32 bits.
   assign cmd_len   = (remaining_q < MaxCmdLen) ? remaining_q : MaxCmdLen;
   assign cmd_beats = (cmd_len + 32'(BeatBytes - 1)) >> BeatShift;

   assign m_data_data = s_data_data;
   assign m_data_keep = '1;
   assign error       = error_q;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      remaining_d    = remaining_q;
      chunk_beats_d  = chunk_beats_q;
      beat_cnt_d     = beat_cnt_q;
      cmd_cnt_d      = cmd_cnt_q;
      sts_cnt_d      = sts_cnt_q;
      error_d        = error_q;
      busy           = 1'b0;
      done           = 1'b0;
      m_cmd_valid    = 1'b0;
      m_cmd_address  = '0;
      m_cmd_length   = '0;
      s_data_ready   = 1'b0;
      m_data_valid   = 1'b0;
      m_data_last    = 1'b0;

      // Status may overtake the data phase; it is counted in any active state.
      s_status_ready = (state_q != StIdle) && (state_q != StFin);
      if (s_status_valid && s_status_ready) begin
         sts_cnt_d = sts_cnt_q + 32'd1;
         if (s_status_data != 8'h00) begin
            error_d = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               error_d    = 1'b0;
               cmd_cnt_d  = '0;
               sts_cnt_d  = '0;
               beat_cnt_d = '0;
               if (total_len == 32'd0) begin
                  state_d = StFin;
               end else begin
                  addr_d      = base_addr;
                  remaining_d = total_len;
                  state_d     = StCmd;
               end
            end
         end
         StCmd: begin
            busy          = 1'b1;
            m_cmd_valid   = 1'b1;
            m_cmd_address = addr_q;
            m_cmd_length  = cmd_len;
            if (m_cmd_ready) begin
               cmd_cnt_d     = cmd_cnt_q + 32'd1;
               addr_d        = addr_q + 64'(cmd_len);  // wraps modulo 2^64
               remaining_d   = remaining_q - cmd_len;
               chunk_beats_d = cmd_beats;
               beat_cnt_d    = '0;
               state_d       = StData;
            end
         end
         StData: begin
            busy         = 1'b1;
            m_data_valid = s_data_valid;
            s_data_ready = m_data_ready;
            m_data_last  = (beat_cnt_q == chunk_beats_q - 32'd1);
            if (s_data_valid && m_data_ready) begin
               beat_cnt_d = beat_cnt_q + 32'd1;
               if (m_data_last) begin
                  state_d = (remaining_q != 32'd0) ? StCmd : StWaitSts;
               end
            end
         end
         StWaitSts: begin
            busy = 1'b1;
            // Compare against the post-update count so a status in this cycle completes the job.
            if (sts_cnt_d == cmd_cnt_q) begin
               state_d = StFin;
            end
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         remaining_q   <= '0;
         chunk_beats_q <= '0;
         beat_cnt_q    <= '0;
         cmd_cnt_q     <= '0;
         sts_cnt_q     <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         chunk_beats_q <= chunk_beats_d;
         beat_cnt_q    <= beat_cnt_d;
         cmd_cnt_q     <= cmd_cnt_d;
         sts_cnt_q     <= sts_cnt_d;
         error_q       <= error_d;
      end
   end

endmodule
